// File: rtl/cpu_io_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_io_pkg
// Brief  : Shared constants for the 6510 on-chip I/O port model.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_io_pkg;

    localparam logic [15:0] ADDR_DDR  = 16'h0000;
    localparam logic [15:0] ADDR_DATA = 16'h0001;

    localparam logic [7:0]  DDR_RST   = 8'h00;
    localparam logic [7:0]  DATA_RST  = 8'h00;

    localparam int PORT_W = 6;

    localparam int PIN_LORAM      = 0;
    localparam int PIN_HIRAM      = 1;
    localparam int PIN_CHAREN     = 2;
    localparam int PIN_CASS_WRT   = 3;
    localparam int PIN_CASS_SENSE = 4;
    localparam int PIN_CASS_MOTOR = 5;

endpackage : cpu_io_pkg
`default_nettype wire

// File: rtl/cpu_io_fade.sv
`default_nettype none
// ============================================================================
// Module : cpu_io_fade
// Brief  : Float latch plus fade counter for one undriven bit 6/7.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_io_fade #(
    parameter int FADE_CYCLES = 350000,
    parameter int FADE_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_en,
    input  logic drive,
    input  logic value,
    output logic float_rd
);

    localparam logic [FADE_W-1:0] c_fade_load = FADE_W'(FADE_CYCLES);

    logic              r_float;
    logic [FADE_W-1:0] r_cnt;
    logic              w_float_nxt;
    logic [FADE_W-1:0] w_cnt_nxt;

    // Next state assumes a cpu_en cycle; reads use it so that a read on the
    // cycle the counter expires already sees the faded level.
    always_comb begin
        w_float_nxt = r_float;
        w_cnt_nxt   = r_cnt;
        if (drive) begin
            w_float_nxt = value;
            w_cnt_nxt   = c_fade_load;
        end else if (r_float && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == FADE_W'(1)) begin
                w_float_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_float <= 1'b0;
            r_cnt   <= '0;
        end else if (cpu_en) begin
            r_float <= w_float_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign float_rd = w_float_nxt;

endmodule : cpu_io_fade
`default_nettype wire

// File: rtl/cpu_io_port.sv
`default_nettype none
// ============================================================================
// Module : cpu_io_port
// Brief  : 6510 on-chip I/O port ($0000 DDR, $0001 DATA) with pull-ups and
//          bit 6/7 fade emulation enabled by CPU_IO_PORT_FADE_EN.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_io_port
    import cpu_io_pkg::*;
#(
    parameter int FADE_CYCLES = 350000,
    parameter int FADE_W      = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [15:0] A,
    input  logic        R__W,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic [5:0]  pin_in,
    output logic [5:0]  pin_out,
    output logic [5:0]  pin_oe,
    output logic        _LORAM,
    output logic        _HIRAM,
    output logic        _CHAREN,
    output logic        CASS_WRT,
    output logic        CASS_MOTOR
);

    logic [7:0] r_ddr;
    logic [7:0] r_data;
    logic [7:0] w_rd_port;
    logic [7:6] w_float_rd;
    logic       w_hit;

    // Address decode only qualifies the access; external RAM still sees writes.
    assign w_hit = (A[15:1] == ADDR_DDR[15:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ddr  <= DDR_RST;
            r_data <= DATA_RST;
        end else if (cpu_en && w_hit && !R__W) begin
            if (A[0] == ADDR_DATA[0]) begin
                r_data <= din;
            end else begin
                r_ddr <= din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= 8'h00;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= cpu_en && w_hit && R__W;
            if (cpu_en && w_hit && R__W) begin
                dout <= (A[0] == ADDR_DATA[0]) ? w_rd_port : r_ddr;
            end
        end
    end

    for (genvar i = 0; i < PORT_W; i++) begin : g_pin
        assign pin_out[i]   = r_ddr[i] ? r_data[i] : 1'b1;
        assign w_rd_port[i] = r_ddr[i] ? r_data[i] : pin_in[i];
    end

`ifdef CPU_IO_PORT_FADE_EN
    for (genvar i = 6; i < 8; i++) begin : g_fade
        cpu_io_fade #(
            .FADE_CYCLES (FADE_CYCLES),
            .FADE_W      (FADE_W)
        ) u_fade (
            .clk      (clk),
            .rst      (rst),
            .cpu_en   (cpu_en),
            .drive    (r_ddr[i]),
            .value    (r_data[i]),
            .float_rd (w_float_rd[i])
        );
    end
`else
    // Without fade the floating bits simply remember the last driven level.
    logic [7:6] r_float;
    for (genvar i = 6; i < 8; i++) begin : g_hold
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_float[i] <= 1'b0;
            end else if (cpu_en && r_ddr[i]) begin
                r_float[i] <= r_data[i];
            end
        end
        assign w_float_rd[i] = r_ddr[i] ? r_data[i] : r_float[i];
    end
`endif

    for (genvar i = 6; i < 8; i++) begin : g_rd_hi
        assign w_rd_port[i] = r_ddr[i] ? r_data[i] : w_float_rd[i];
    end

    if ((64'd1 << FADE_W) <= 64'(FADE_CYCLES)) begin : g_fade_w_check
        $error("cpu_io_port: FADE_W too narrow for FADE_CYCLES");
    end

    assign pin_oe     = r_ddr[PORT_W-1:0];
    assign _LORAM     = pin_out[PIN_LORAM];
    assign _HIRAM     = pin_out[PIN_HIRAM];
    assign _CHAREN    = pin_out[PIN_CHAREN];
    assign CASS_WRT   = pin_out[PIN_CASS_WRT];
    assign CASS_MOTOR = pin_out[PIN_CASS_MOTOR];

endmodule : cpu_io_port
`default_nettype wire

// File: tb/tb_cpu_io_port.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_io_port
// Brief  : Directed self-checking bench for cpu_io_port (FADE_CYCLES = 8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_io_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en = 1'b0;
    logic [15:0] A = 16'h0000;
    logic        R__W = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [5:0]  pin_in = 6'h3F;
    logic [5:0]  pin_out;
    logic [5:0]  pin_oe;
    logic        lo_ram, hi_ram, char_en, cass_wrt, cass_motor;

    int checks   = 0;
    int failures = 0;

    cpu_io_port #(
        .FADE_CYCLES (8),
        .FADE_W      (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_en     (cpu_en),
        .A          (A),
        .R__W       (R__W),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .pin_in     (pin_in),
        .pin_out    (pin_out),
        .pin_oe     (pin_oe),
        ._LORAM     (lo_ram),
        ._HIRAM     (hi_ram),
        ._CHAREN    (char_en),
        .CASS_WRT   (cass_wrt),
        .CASS_MOTOR (cass_motor)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, sample 1ns after the rising edge.
    task automatic bus(input logic en, input logic [15:0] addr, input logic rw, input logic [7:0] d);
        @(negedge clk);
        cpu_en = en;
        A      = addr;
        R__W   = rw;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] d);
        bus(1'b1, addr, 1'b0, d);
    endtask

    task automatic rd(input logic [15:0] addr);
        bus(1'b1, addr, 1'b1, 8'h00);
    endtask

    task automatic idle();
        bus(1'b0, 16'h1234, 1'b1, 8'h00);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_pin_out", 16'(pin_out), 16'h003F);
        check("rst_pin_oe", 16'(pin_oe), 16'h0000);
        check("rst_dout_valid", 16'(dout_valid), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reads after reset with pull-ups on all pins
        rd(16'h0000);
        check("rd_ddr_rst", 16'(dout), 16'h0000);
        check("rd_ddr_valid", 16'(dout_valid), 16'h0001);
        rd(16'h0001);
        check("rd_data_rst", 16'(dout), 16'h003F);
        check("rst_maps", 16'({lo_ram, hi_ram, char_en}), 16'h0007);
        idle();
        check("valid_drop", 16'(dout_valid), 16'h0000);

        // DDR=2F, DATA=35
        wr(16'h0000, 8'h2F);
        wr(16'h0001, 8'h35);
        check("loram", 16'(lo_ram), 16'h0001);
        check("hiram", 16'(hi_ram), 16'h0000);
        check("charen", 16'(char_en), 16'h0001);
        check("cass_motor", 16'(cass_motor), 16'h0001);
        check("cass_wrt", 16'(cass_wrt), 16'h0000);
        check("pin_out_35", 16'(pin_out), 16'h0035);
        check("pin_oe_2f", 16'(pin_oe), 16'h002F);
        pin_in = 6'h2F;
        rd(16'h0001);
        check("rd_data_25", 16'(dout), 16'h0025);
        check("wr_keeps_dout_pre", 16'(dout), 16'h0025);
        wr(16'h0001, 8'h35);
        check("wr_keeps_dout", 16'(dout), 16'h0025);
        check("wr_no_valid", 16'(dout_valid), 16'h0000);
        pin_in = 6'h3F;

        // Release all outputs back to pull-ups
        wr(16'h0000, 8'h00);
        check("pullup_pin_out", 16'(pin_out), 16'h003F);
        check("pullup_pin_oe", 16'(pin_oe), 16'h0000);

        // Asynchronous reset during a read
        wr(16'h0000, 8'h2F);
        rd(16'h0000);
        check("pre_rst_dout", 16'(dout), 16'h002F);
        @(negedge clk);
        cpu_en = 1'b1;
        A      = 16'h0001;
        R__W   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_dout", 16'(dout), 16'h0000);
        check("mid_rst_valid", 16'(dout_valid), 16'h0000);
        check("mid_rst_oe", 16'(pin_oe), 16'h0000);
        check("mid_rst_pin", 16'(pin_out), 16'h003F);
        @(posedge clk);
        #1;
        check("post_edge_valid", 16'(dout_valid), 16'h0000);
        check("post_edge_dout", 16'(dout), 16'h0000);
        @(negedge clk);
        rst    = 1'b0;
        cpu_en = 1'b0;

        // Fade of bits 6/7 once undriven
        wr(16'h0000, 8'hC0);
        wr(16'h0001, 8'hC0);
        wr(16'h0000, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            rd(16'h0001);
`ifdef CPU_IO_PORT_FADE_EN
            check($sformatf("fade_rd%0d", k), 16'(dout), (k <= 7) ? 16'h00FF : 16'h003F);
`else
            check($sformatf("hold_rd%0d", k), 16'(dout), 16'h00FF);
`endif
        end

        // Aliased addresses neither hit nor modify the port
        wr(16'h0002, 8'hFF);
        wr(16'hFFFF, 8'hFF);
        check("alias_oe", 16'(pin_oe), 16'h0000);
        rd(16'h0002);
        check("alias_rd2_valid", 16'(dout_valid), 16'h0000);
        rd(16'hFFFF);
        check("alias_rdF_valid", 16'(dout_valid), 16'h0000);
        rd(16'h0000);
        check("alias_ddr", 16'(dout), 16'h0000);
        wr(16'h0000, 8'h3F);
        check("alias_data", 16'(pin_out), 16'h0000);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cpu_io_port
`default_nettype wire
